spi_shader_loader: RTL and testbench

Parametrised SPI slave that loads and reads back shader program memory and owns the mode/pause control bits of the tiny shader core. It sits between the bidirectional PMOD pins (`spi_cs`, `spi_mosi`, `spi_miso`, `spi_sclk`) and the shader memory write/read ports. It generalises the fixed 8-bit, 16-entry load path to configurable instruction width and depth. It adds auto-increment streaming, wrap-around, readback and a control register.

---
 rtl/spi_loader_pkg.sv | 32 +++
 rtl/spi_sync_edge.sv | 48 ++++
 rtl/spi_shader_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_shader_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_loader_pkg.sv
// ============================================================================
// Module : spi_loader_pkg
// Brief  : Shared opcodes, FSM states and constants for the SPI shader loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spi_loader_pkg;

    localparam int         CMD_W     = 8;
    localparam logic [3:0] STATUS_ID = 4'hA;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_CTRL   = 2'b10,
        OP_STATUS = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_CTRL   = 3'd4,
        ST_STATUS = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module : spi_sync_edge
// Brief  : 2-FF synchroniser with registered rise/fall pulses (3 clk latency).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    // RST_VAL lets an idle-high pin (CS) come out of reset without a fake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/spi_shader_loader.sv
// ============================================================================
// Module : spi_shader_loader
// Brief  : SPI mode-0 slave loading/reading shader memory plus control bits.
//          Readback (READ/STATUS, MISO) is built only with SPI_READBACK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_shader_loader
    import spi_loader_pkg::*;
#(
    parameter  int INSTR_W = 8,
    parameter  int DEPTH   = 16,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_cs,
    input  logic               spi_sclk,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               spi_miso_oe,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               ctrl_mode,
    output logic               ctrl_pause,
    output logic               loading
);

    localparam int BCW = $clog2(INSTR_W);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .din_i(spi_cs),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din_i(spi_sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .din_i(spi_mosi),
        .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    state_e             state_q;
    logic [BCW-1:0]     bitcnt_q;
    logic [INSTR_W-1:0] shift_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [INSTR_W-1:0] mem_wdata_q;
    logic               ctrl_mode_q;
    logic               ctrl_pause_q;
    logic               loading_q;

    logic [INSTR_W-1:0] w_shift_nxt;
    logic               w_last_word;
    logic               w_last_byte;

    assign w_shift_nxt = {shift_q[INSTR_W-2:0], mosi_s};
    assign w_last_word = (bitcnt_q == BCW'(INSTR_W - 1));
    assign w_last_byte = (bitcnt_q == BCW'(CMD_W - 1));

`ifdef SPI_READBACK_EN
    logic [ADDR_W-1:0]  raddr_q;
    logic [1:0]         rd_pipe_q;
    logic [INSTR_W-1:0] rd_data_q;
    logic [INSTR_W-1:0] rd_shift_q;
    logic               load_pend_q;
    logic [INSTR_W-1:0] w_status;

    assign w_status = INSTR_W'({STATUS_ID, 2'b00, ctrl_pause_q, ctrl_mode_q}) << (INSTR_W - CMD_W);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ctrl_mode_q  <= 1'b0;
            ctrl_pause_q <= 1'b0;
            loading_q    <= 1'b0;
`ifdef SPI_READBACK_EN
            raddr_q      <= '0;
            rd_pipe_q    <= '0;
            rd_data_q    <= '0;
            rd_shift_q   <= '0;
            load_pend_q  <= 1'b0;
`endif
        end else begin
            mem_we_q  <= 1'b0;
            loading_q <= (state_q == ST_WRITE);
`ifdef SPI_READBACK_EN
            // Memory read has one clk of latency after mem_raddr is driven.
            rd_pipe_q <= {rd_pipe_q[0], 1'b0};
            if (rd_pipe_q[1]) begin
                rd_data_q <= mem_rdata;
            end
`endif
            if (cs_rise) begin
                state_q  <= ST_IDLE;
                bitcnt_q <= '0;
                shift_q  <= '0;
`ifdef SPI_READBACK_EN
                rd_shift_q  <= '0;
                load_pend_q <= 1'b0;
`endif
            end else begin
`ifdef SPI_READBACK_EN
                if ((state_q == ST_READ || state_q == ST_STATUS) && sclk_fall) begin
                    if (load_pend_q) begin
                        rd_shift_q  <= rd_data_q;
                        load_pend_q <= 1'b0;
                    end else begin
                        rd_shift_q <= {rd_shift_q[INSTR_W-2:0], 1'b0};
                    end
                end
`endif
                case (state_q)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_q  <= ST_CMD;
                            bitcnt_q <= '0;
                            shift_q  <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift_q  <= w_shift_nxt;
                            bitcnt_q <= w_last_byte ? '0 : bitcnt_q + 1'b1;
                            if (w_last_byte) begin
                                addr_q <= w_shift_nxt[ADDR_W-1:0];
                                case (opcode_e'(w_shift_nxt[7:6]))
                                    OP_WRITE: state_q <= ST_WRITE;
                                    OP_CTRL:  state_q <= ST_CTRL;
`ifdef SPI_READBACK_EN
                                    OP_READ: begin
                                        state_q     <= ST_READ;
                                        raddr_q     <= w_shift_nxt[ADDR_W-1:0];
                                        rd_pipe_q   <= {rd_pipe_q[0], 1'b1};
                                        load_pend_q <= 1'b1;
                                    end
                                    OP_STATUS: begin
                                        state_q     <= ST_STATUS;
                                        rd_data_q   <= w_status;
                                        load_pend_q <= 1'b1;
                                    end
`endif
                                    default: state_q <= ST_DONE;
                                endcase
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (sclk_rise) begin
                            shift_q  <= w_shift_nxt;
                            bitcnt_q <= w_last_word ? '0 : bitcnt_q + 1'b1;
                            if (w_last_word) begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= addr_q;
                                mem_wdata_q <= w_shift_nxt;
                                addr_q      <= addr_q + 1'b1;
                            end
                        end
                    end
                    ST_CTRL: begin
                        if (sclk_rise) begin
                            shift_q  <= w_shift_nxt;
                            bitcnt_q <= w_last_byte ? '0 : bitcnt_q + 1'b1;
                            if (w_last_byte) begin
                                ctrl_mode_q  <= w_shift_nxt[0];
                                ctrl_pause_q <= w_shift_nxt[1];
                                state_q      <= ST_DONE;
                            end
                        end
                    end
`ifdef SPI_READBACK_EN
                    ST_READ: begin
                        if (sclk_rise) begin
                            bitcnt_q <= w_last_word ? '0 : bitcnt_q + 1'b1;
                            if (w_last_word) begin
                                addr_q      <= addr_q + 1'b1;
                                raddr_q     <= addr_q + 1'b1;
                                rd_pipe_q   <= {rd_pipe_q[0], 1'b1};
                                load_pend_q <= 1'b1;
                            end
                        end
                    end
                    ST_STATUS: begin
                        if (sclk_rise) begin
                            bitcnt_q <= w_last_byte ? '0 : bitcnt_q + 1'b1;
                            if (w_last_byte) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign ctrl_mode  = ctrl_mode_q;
    assign ctrl_pause = ctrl_pause_q;
    assign loading    = loading_q;

    logic w_unused;
    assign w_unused = ^{sclk_lvl, mosi_rise, mosi_fall, shift_q[INSTR_W-1]};

`ifdef SPI_READBACK_EN
    assign spi_miso    = rd_shift_q[INSTR_W-1] & (state_q == ST_READ || state_q == ST_STATUS);
    assign spi_miso_oe = ~cs_lvl;
    assign mem_raddr   = raddr_q;
`else
    logic w_unused_rb;
    assign w_unused_rb = ^{mem_rdata, cs_lvl};
    assign spi_miso    = 1'b0;
    assign spi_miso_oe = 1'b0;
    assign mem_raddr   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_shader_loader.sv
// ============================================================================
// Module : tb_spi_shader_loader
// Brief  : Directed bench for spi_shader_loader (8x16 and 16x64 instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_shader_loader;

    localparam int HALF = 8;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs8 = 1'b1, cs16 = 1'b1, sclk = 1'b0, mosi = 1'b0;

    logic        miso8, oe8, we8, mode8, pause8, load8;
    logic [3:0]  addr8, raddr8;
    logic [7:0]  wdata8, rdata8;
    logic        miso16, oe16, we16, mode16, pause16, load16;
    logic [5:0]  addr16, raddr16;
    logic [15:0] wdata16;
    logic [15:0] rdata16 = 16'h0000;

    logic [7:0]  mem8 [16];
    int          wa8[$], wa16[$];
    logic [31:0] wd8[$], wd16[$];
    int          we_noload;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] rx;

    always #5 clk = ~clk;

    spi_shader_loader #(.INSTR_W(8), .DEPTH(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .spi_cs(cs8), .spi_sclk(sclk), .spi_mosi(mosi),
        .spi_miso(miso8), .spi_miso_oe(oe8), .mem_we(we8), .mem_addr(addr8),
        .mem_wdata(wdata8), .mem_raddr(raddr8), .mem_rdata(rdata8),
        .ctrl_mode(mode8), .ctrl_pause(pause8), .loading(load8)
    );

    spi_shader_loader #(.INSTR_W(16), .DEPTH(64)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .spi_cs(cs16), .spi_sclk(sclk), .spi_mosi(mosi),
        .spi_miso(miso16), .spi_miso_oe(oe16), .mem_we(we16), .mem_addr(addr16),
        .mem_wdata(wdata16), .mem_raddr(raddr16), .mem_rdata(rdata16),
        .ctrl_mode(mode16), .ctrl_pause(pause16), .loading(load16)
    );

    always @(posedge clk) rdata8 <= mem8[raddr8];

    // Each cycle with mem_we high is one logged write, so a stretched pulse shows up as extras.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we8) begin
                wa8.push_back(int'(addr8));
                wd8.push_back(32'(wdata8));
                if (!load8) we_noload++;
            end
            if (we16) begin
                wa16.push_back(int'(addr16));
                wd16.push_back(32'(wdata16));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rxd);
        rxd = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rxd = {rxd[30:0], miso8 | miso16};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_lo(input bit wide);
        if (wide) cs16 = 1'b0; else cs8 = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (HALF) @(negedge clk);
        cs8  = 1'b1;
        cs16 = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem8[i] = 8'h00;
        mem8[5] = 8'h5A;
        mem8[6] = 8'hC3;
        we_noload = 0;

        repeat (5) @(negedge clk);
        check("rst_we",    32'(we8),    0);
        check("rst_load",  32'(load8),  0);
        check("rst_mode",  32'(mode8),  0);
        check("rst_pause", 32'(pause8), 0);
        check("rst_miso",  32'(miso8),  0);
        check("rst_oe",    32'(oe8),    0);
        check("rst_addr",  32'(addr8),  0);
        check("rst_wdata", 32'(wdata8), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // WRITE stream with wrap 14,15,0
        cs_lo(0);
        spi_bits(32'h0E, 8, rx);
        repeat (6) @(negedge clk);
        check("wr_loading_on", 32'(load8), 1);
        spi_bits(32'h11, 8, rx);
        spi_bits(32'h22, 8, rx);
        spi_bits(32'h33, 8, rx);
        check("wr_loading_end", 32'(load8), 1);
        cs_hi();
        check("wr_loading_off", 32'(load8), 0);
        check("wr_count", 32'(wa8.size()), 3);
        if (wa8.size() == 3) begin
            check("wr0_addr", 32'(wa8[0]), 14); check("wr0_data", wd8[0], 32'h11);
            check("wr1_addr", 32'(wa8[1]), 15); check("wr1_data", wd8[1], 32'h22);
            check("wr2_addr", 32'(wa8[2]), 0);  check("wr2_data", wd8[2], 32'h33);
        end
        check("wr_we_while_loading", 32'(we_noload), 0);

        // Partial word abort, then a clean write
        wa8.delete(); wd8.delete();
        cs_lo(0);
        spi_bits(32'h00, 8, rx);
        spi_bits(32'h16, 5, rx);
        cs_hi();
        check("abort_nowrite", 32'(wa8.size()), 0);
        cs_lo(0);
        spi_bits(32'h03, 8, rx);
        spi_bits(32'hAB, 8, rx);
        cs_hi();
        check("abort_next_count", 32'(wa8.size()), 1);
        if (wa8.size() == 1) begin
            check("abort_next_addr", 32'(wa8[0]), 3);
            check("abort_next_data", wd8[0], 32'hAB);
        end

        // READ stream from address 5
        wa8.delete(); wd8.delete();
        cs_lo(0);
        check("rd_oe", 32'(oe8), 32'(RB));
        spi_bits(32'h45, 8, rx);
        check("rd_cmd_miso", rx, 0);
        spi_bits(32'h00, 8, rx);
        check("rd_word0", rx, RB ? 32'h5A : 32'h0);
        spi_bits(32'h00, 8, rx);
        check("rd_word1", rx, RB ? 32'hC3 : 32'h0);
        cs_hi();
        check("rd_oe_off", 32'(oe8), 0);
        check("rd_nowrite", 32'(wa8.size()), 0);

        // CTRL: bits land in the right places
        cs_lo(0);
        spi_bits(32'h80, 8, rx);
        spi_bits(32'h01, 8, rx);
        cs_hi();
        check("ctrl1_mode",  32'(mode8),  1);
        check("ctrl1_pause", 32'(pause8), 0);
        cs_lo(0);
        spi_bits(32'h80, 8, rx);
        spi_bits(32'h03, 8, rx);
        cs_hi();
        check("ctrl3_mode",  32'(mode8),  1);
        check("ctrl3_pause", 32'(pause8), 1);
        check("ctrl_nowrite", 32'(wa8.size()), 0);

        // STATUS, then DONE stays quiet
        cs_lo(0);
        spi_bits(32'hC0, 8, rx);
        check("st_cmd_miso", rx, 0);
        spi_bits(32'h00, 8, rx);
        check("st_byte", rx, RB ? 32'hA3 : 32'h0);
        spi_bits(32'h00, 8, rx);
        check("st_done_miso", rx, 0);
        cs_hi();

        // 16-bit words, 64 deep: wrap 63 -> 0
        cs_lo(1);
        spi_bits(32'h3F, 8, rx);
        spi_bits(32'hBEEF, 16, rx);
        spi_bits(32'h1234, 16, rx);
        cs_hi();
        check("w16_count", 32'(wa16.size()), 2);
        if (wa16.size() == 2) begin
            check("w16_0_addr", 32'(wa16[0]), 63); check("w16_0_data", wd16[0], 32'hBEEF);
            check("w16_1_addr", 32'(wa16[1]), 0);  check("w16_1_data", wd16[1], 32'h1234);
        end
        check("w16_dut8_idle", 32'(wa8.size()), 0);

        // Asynchronous reset in the middle of a WRITE
        cs_lo(0);
        spi_bits(32'h00, 8, rx);
        spi_bits(32'h09, 4, rx);
        check("ar_loading_pre", 32'(load8), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_load",  32'(load8),  0);
        check("ar_mode",  32'(mode8),  0);
        check("ar_pause", 32'(pause8), 0);
        check("ar_we",    32'(we8),    0);
        check("ar_oe",    32'(oe8),    0);
        check("ar_miso",  32'(miso8),  0);
        cs8 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        wa8.delete(); wd8.delete();
        cs_lo(0);
        spi_bits(32'h07, 8, rx);
        spi_bits(32'h5C, 8, rx);
        cs_hi();
        check("ar_next_count", 32'(wa8.size()), 1);
        if (wa8.size() == 1) begin
            check("ar_next_addr", 32'(wa8[0]), 7);
            check("ar_next_data", wd8[0], 32'h5C);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
